vscale_csr_arbiter: RTL
=======================

Name: vscale_csr_arbiter

Overview:
- Shares the single CSR file port between the core pipeline (requester 0, latency-critical) and a debug transport (requester 1).
- Pipeline accesses pass straight through combinationally. A debug access is captured, held until a free slot, issued for exactly one cycle, and answered with a valid/ready response.
- A starvation counter can force a pipeline stall so debug access is guaranteed to make progress.

Parameters:
- MAX_WAIT, 16: WAIT cycles after which the pipeline is stalled for debug (starvation feature only).
- WAIT_CNT_WIDTH, 5: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- pipe_req  in  1  pipeline CSR access request
- pipe_addr  in  `CSR_ADDR_WIDTH  pipeline CSR address
- pipe_cmd  in  `CSR_CMD_WIDTH  pipeline CSR command
- pipe_wdata  in  `XPR_LEN  pipeline write data
- pipe_rdata  out  `XPR_LEN  read data to pipeline
- pipe_illegal  out  1  illegal-access flag to pipeline
- pipe_stall  out  1  pipeline must hold its current instruction and not retire or trap
- trap_busy  in  1  exception, mret or interrupt_taken active this cycle
- dbg_req  in  1  debug request
- dbg_gnt  out  1  debug request accepted (1-cycle pulse)
- dbg_addr  in  `CSR_ADDR_WIDTH  debug CSR address
- dbg_cmd  in  `CSR_CMD_WIDTH  debug CSR command
- dbg_wdata  in  `XPR_LEN  debug write data
- dbg_rvalid  out  1  debug response valid
- dbg_rready  in  1  debug response accepted
- dbg_rdata  out  `XPR_LEN  CSR value before the access
- dbg_error  out  1  debug access was illegal or malformed
- csr_req  out  1  to CSR file req
- csr_addr  out  `CSR_ADDR_WIDTH  to CSR file addr
- csr_cmd  out  `CSR_CMD_WIDTH  to CSR file cmd
- csr_wdata  out  `XPR_LEN  to CSR file wdata
- csr_rdata  in  `XPR_LEN  from CSR file rdata
- csr_illegal  in  1  from CSR file illegal_access

Behaviour:
- FSM states: IDLE, WAIT, ISSUE, RESP. On reset the state is IDLE.
- Reset values: dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0, dbg_error=0, wait counter=0, captured request cleared.
- Reset mid-operation discards any captured or pending debug access; no CSR write occurs.
- Passthrough in every state except ISSUE:
  - csr_req/addr/cmd/wdata = pipe_*.
  - pipe_rdata = csr_rdata; pipe_illegal = csr_illegal.
- IDLE:
  - dbg_gnt = dbg_req, combinational.
  - On dbg_req, capture dbg_addr/cmd/wdata.
  - If captured cmd[2]=0 (not a valid CSR op), go to RESP with dbg_rdata=0, dbg_error=1.
  - Otherwise go to WAIT with counter cleared.
  - dbg_gnt is never asserted outside IDLE.
- WAIT:
  - If pipe_req=0 and trap_busy=0, go to ISSUE next cycle.
  - Otherwise the counter increments, saturating at MAX_WAIT.
- ISSUE (exactly 1 cycle):
  - csr_addr/cmd/wdata = captured values.
  - csr_req = !csr_illegal && !trap_busy; an illegal write never reaches the CSR file.
  - pipe_stall=1, pipe_rdata=0, pipe_illegal=0.
  - If trap_busy=1: no access; return to WAIT with the counter unchanged.
  - Otherwise latch dbg_rdata=csr_rdata (pre-write value) and dbg_error=csr_illegal, then go to RESP.
- RESP:
  - dbg_rvalid=1; dbg_rdata and dbg_error held stable.
  - On dbg_rready go to IDLE. A new dbg_req is granted no earlier than the cycle after.
- Read-modify-write (SET/CLEAR) is resolved inside the CSR file in the ISSUE cycle; the arbiter does no arithmetic.
- Simultaneous dbg_req and pipe_req in IDLE: pipeline is served that cycle; debug is captured.
- A pipeline access is never split or delayed by the arbiter except through pipe_stall.

Optional Feature:
- Macro: VSCALE_CSR_ARB_STARVE_EN.
- Defined: in WAIT, when counter==MAX_WAIT, assert pipe_stall=1. Next state is ISSUE if trap_busy=0, regardless of pipe_req; pipe_req is ignored while stalled.
- Undefined: pipe_stall is asserted only in ISSUE, and debug may wait indefinitely while pipe_req stays high.

Test Plan:
1. Idle pipe; debug READ (cmd=4) of 0x340 with mscratch=0x1234 -> gnt in cycle 0, csr_req in cycle 2, rvalid cycle 3 with rdata=0x1234, error=0.
2. Debug SET (cmd=6) of 0x340, wdata=0x0F0 over mscratch=0x100 -> rdata=0x100; a following pipe read returns 0x1F0.
3. Debug WRITE (cmd=5) to 0xF11 (read-only region) -> csr_req=0 in ISSUE, dbg_error=1, mvendorid unchanged.
4. pipe_req held high 40 cycles with STARVE_EN, MAX_WAIT=16 -> pipe_stall rises in cycle 17 of WAIT, ISSUE follows; without the macro, no ISSUE until pipe_req drops.
5. trap_busy=1 during ISSUE -> csr_req=0, back to WAIT; access completes on the next free cycle with correct rdata.
6. reset_n=0 while in RESP with dbg_rready=0 -> next cycle dbg_rvalid=0, state IDLE, dbg_gnt responds to a new dbg_req.

Source files
------------

// File: rtl/vscale_csr_arbiter.sv
// Arbitrates the CSR file port between the core pipeline (pass-through) and a debug requester.
// Define VSCALE_CSR_ARB_STARVE_EN to stall the pipeline after MAX_WAIT blocked cycles of debug.

`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef CSR_CMD_WIDTH
`define CSR_CMD_WIDTH 3
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module vscale_csr_arbiter #(
    parameter int MAX_WAIT       = 16,
    parameter int WAIT_CNT_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pipe_req,
    input  logic [`CSR_ADDR_WIDTH-1:0] pipe_addr,
    input  logic [`CSR_CMD_WIDTH-1:0]  pipe_cmd,
    input  logic [`XPR_LEN-1:0]        pipe_wdata,
    output logic [`XPR_LEN-1:0]        pipe_rdata,
    output logic                       pipe_illegal,
    output logic                       pipe_stall,
    input  logic                       trap_busy,
    input  logic                       dbg_req,
    output logic                       dbg_gnt,
    input  logic [`CSR_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [`CSR_CMD_WIDTH-1:0]  dbg_cmd,
    input  logic [`XPR_LEN-1:0]        dbg_wdata,
    output logic                       dbg_rvalid,
    input  logic                       dbg_rready,
    output logic [`XPR_LEN-1:0]        dbg_rdata,
    output logic                       dbg_error,
    output logic                       csr_req,
    output logic [`CSR_ADDR_WIDTH-1:0] csr_addr,
    output logic [`CSR_CMD_WIDTH-1:0]  csr_cmd,
    output logic [`XPR_LEN-1:0]        csr_wdata,
    input  logic [`XPR_LEN-1:0]        csr_rdata,
    input  logic                       csr_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        RESP
    } state_t;

    localparam logic [WAIT_CNT_WIDTH-1:0] MAX_CNT = WAIT_CNT_WIDTH'(MAX_WAIT);

    state_t                      state_q, state_d;
    logic [`CSR_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [`CSR_CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [`XPR_LEN-1:0]         wdata_q, wdata_d;
    logic [WAIT_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [`XPR_LEN-1:0]         rdata_q, rdata_d;
    logic                        error_q, error_d;
    logic                        at_max;
    logic                        starve_stall;

    assign at_max = (cnt_q == MAX_CNT);

`ifdef VSCALE_CSR_ARB_STARVE_EN
    assign starve_stall = (state_q == WAIT) && at_max;
`else
    assign starve_stall = 1'b0;
`endif

    assign dbg_rdata = rdata_q;
    assign dbg_error = error_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        csr_req      = pipe_req;
        csr_addr     = pipe_addr;
        csr_cmd      = pipe_cmd;
        csr_wdata    = pipe_wdata;
        pipe_rdata   = csr_rdata;
        pipe_illegal = csr_illegal;
        pipe_stall   = starve_stall;
        dbg_gnt      = 1'b0;
        dbg_rvalid   = 1'b0;

        unique case (state_q)
            IDLE: begin
                dbg_gnt = dbg_req;
                if (dbg_req) begin
                    addr_d  = dbg_addr;
                    cmd_d   = dbg_cmd;
                    wdata_d = dbg_wdata;
                    // Commands without bit 2 are not CSR operations; answer immediately with an error.
                    if (!dbg_cmd[2]) begin
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!trap_busy && (!pipe_req || starve_stall)) begin
                    state_d = ISSUE;
                end else if (!at_max) begin
                    cnt_d = cnt_q + WAIT_CNT_WIDTH'(1);
                end
            end
            ISSUE: begin
                csr_addr     = addr_q;
                csr_cmd      = cmd_q;
                csr_wdata    = wdata_q;
                // Gated by reset_n so a reset landing on the issue cycle never commits a write.
                csr_req      = reset_n && !csr_illegal && !trap_busy;
                pipe_stall   = 1'b1;
                pipe_rdata   = '0;
                pipe_illegal = 1'b0;
                if (trap_busy) begin
                    state_d = WAIT;
                end else begin
                    rdata_d = csr_rdata;
                    error_d = csr_illegal;
                    state_d = RESP;
                end
            end
            RESP: begin
                dbg_rvalid = 1'b1;
                if (dbg_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
